// File: rtl/unpool_upsample_2x_if.sv
// Stream bundle between a pooled-map source, the 2x upsampler and its consumer.
// slave = upsampler side, master = source/sink side.
interface unpool_upsample_2x_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  valid_in;
  logic                  ready_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_out;
  logic                  ready_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  row_last_out;
  logic                  frame_last_out;

  modport slave (
    input  valid_in, data_in, ready_out,
    output ready_in, valid_out, data_out, row_last_out, frame_last_out
  );

  modport master (
    output valid_in, data_in, ready_out,
    input  ready_in, valid_out, data_out, row_last_out, frame_last_out
  );
endinterface

// File: rtl/unpool_upsample_2x.sv
// 2x2 nearest-neighbour upsampler: each pixel out twice, then the row replayed from a line buffer.
// First copy 1 cycle after accept; no input taken while an output beat is pending on ready_out.
module unpool_upsample_2x #(
  parameter int DATA_WIDTH = 16,
  parameter int IN_WIDTH   = 12,
  parameter int IN_HEIGHT  = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  unpool_upsample_2x_if.slave   px
);
  localparam int COL_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam int REP_W = $clog2(2 * IN_WIDTH);
  localparam int ROW_W = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IN_WIDTH - 1);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(2 * IN_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IN_HEIGHT - 1);

  typedef enum logic [1:0] {S_TAKE, S_DUP0, S_DUP1, S_REP} state_t;

  state_t                state_q, state_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [REP_W-1:0]      rep_idx_q, rep_idx_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [DATA_WIDTH-1:0] out_reg_q, out_reg_d;
  logic [DATA_WIDTH-1:0] lbuf [IN_WIDTH];
  logic                  lbuf_we;
  logic                  in_xfer, out_xfer;
  logic [COL_W-1:0]      rep_rd;

  // rep_idx counts output beats of the replayed row; two beats per stored pixel.
  assign rep_rd = COL_W'(rep_idx_q >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_TAKE;
      col_q     <= '0;
      rep_idx_q <= '0;
      row_q     <= '0;
      out_reg_q <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      rep_idx_q <= rep_idx_d;
      row_q     <= row_d;
      out_reg_q <= out_reg_d;
    end
  end

  always_ff @(posedge clk) begin
    if (lbuf_we) lbuf[col_q] <= px.data_in;
  end

  assign px.ready_in  = (state_q == S_TAKE);
  assign px.valid_out = (state_q != S_TAKE);
  assign px.data_out  = (state_q == S_REP) ? lbuf[rep_rd] : out_reg_q;
  assign in_xfer      = px.valid_in && px.ready_in;
  assign out_xfer     = px.valid_out && px.ready_out;

  assign px.row_last_out   = px.valid_out &&
                             (((state_q == S_DUP1) && (col_q == COL_MAX)) ||
                              ((state_q == S_REP) && (rep_idx_q == REP_MAX)));
  assign px.frame_last_out = px.row_last_out && (state_q == S_REP) && (row_q == ROW_MAX);

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    rep_idx_d = rep_idx_q;
    row_d     = row_q;
    out_reg_d = out_reg_q;
    lbuf_we   = 1'b0;
    unique case (state_q)
      S_TAKE: begin
        if (in_xfer) begin
          lbuf_we   = 1'b1;
          out_reg_d = px.data_in;
          state_d   = S_DUP0;
        end
      end
      S_DUP0: begin
        if (out_xfer) state_d = S_DUP1;
      end
      S_DUP1: begin
        if (out_xfer) begin
          if (col_q == COL_MAX) begin
            col_d     = '0;
            rep_idx_d = '0;
            state_d   = S_REP;
          end else begin
            col_d   = col_q + 1'b1;
            state_d = S_TAKE;
          end
        end
      end
      S_REP: begin
        if (out_xfer) begin
          if (rep_idx_q == REP_MAX) begin
            rep_idx_d = '0;
            state_d   = S_TAKE;
            row_d     = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
          end else begin
            rep_idx_d = rep_idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_TAKE;
    endcase
  end
endmodule

// File: tb/tb_unpool_upsample_2x.sv
// Bench for unpool_upsample_2x: scoreboard fed on input accepts, drained on output beats.
module tb_unpool_upsample_2x;
  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid_in = 1'b0;
  logic [15:0] data_in = '0;
  logic        ready_out = 1'b1;
  logic        sel = 1'b0;
  logic        bp = 1'b0;

  int n_chk = 0;
  int n_pass = 0;
  int beat_cnt = 0;

  unpool_upsample_2x_if #(.DATA_WIDTH(16)) ifa ();
  unpool_upsample_2x_if #(.DATA_WIDTH(16)) ifb ();

  unpool_upsample_2x #(.DATA_WIDTH(16), .IN_WIDTH(W), .IN_HEIGHT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .px(ifa));
  unpool_upsample_2x #(.DATA_WIDTH(16), .IN_WIDTH(W), .IN_HEIGHT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .px(ifb));

  assign ifa.valid_in  = valid_in;
  assign ifa.data_in   = data_in;
  assign ifa.ready_out = ready_out;
  assign ifb.valid_in  = valid_in;
  assign ifb.data_in   = data_in;
  assign ifb.ready_out = ready_out;

  logic        m_valid, m_ready_in, m_rl, m_fl;
  logic [15:0] m_data;
  assign m_valid    = sel ? ifb.valid_out      : ifa.valid_out;
  assign m_ready_in = sel ? ifb.ready_in       : ifa.ready_in;
  assign m_data     = sel ? ifb.data_out       : ifa.data_out;
  assign m_rl       = sel ? ifb.row_last_out   : ifa.row_last_out;
  assign m_fl       = sel ? ifb.frame_last_out : ifa.frame_last_out;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: expected {data,row_last,frame_last} per output beat.
  logic [17:0] q[$];
  logic [15:0] row_buf [W];
  int          mcol = 0;
  int          mrow = 0;
  logic        hold_vld = 1'b0;
  logic [18:0] held;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      mcol = 0;
      mrow = 0;
      hold_vld = 1'b0;
    end else begin
      if (hold_vld) chk("stable", {m_valid, m_data, m_rl, m_fl}, held);
      hold_vld = m_valid && !ready_out;
      held = {m_valid, m_data, m_rl, m_fl};
      if (m_valid && ready_out) begin
        beat_cnt++;
        if (q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else chk("beat", {m_data, m_rl, m_fl}, q.pop_front());
        chk("rdy_excl", m_ready_in, 0);
      end
      if (valid_in && m_ready_in) begin
        automatic int h = sel ? 2 : 1;
        automatic logic rl = (mcol == W - 1);
        row_buf[mcol] = data_in;
        q.push_back({data_in, 2'b00});
        q.push_back({data_in, rl, 1'b0});
        if (rl) begin
          for (int i = 0; i < 2 * W; i++)
            q.push_back({row_buf[i/2], i == 2*W-1, (i == 2*W-1) && (mrow == h-1)});
          mrow = (mrow == h - 1) ? 0 : mrow + 1;
          mcol = 0;
        end else begin
          mcol++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1 ready_out = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    beat_cnt = 0;
  endtask

  task automatic send_px(input logic [15:0] v, input int gap);
    int n;
    bit done;
    n = 0;
    done = 0;
    @(posedge clk);
    #1 valid_in = 1'b1;
    data_in = v;
    while (!done) begin
      @(negedge clk);
      if (m_ready_in) done = 1;
      else if (++n > 300) begin
        chk("accept_timeout", 32'd1, 32'd0);
        done = 1;
      end
    end
    @(posedge clk);
    #1 valid_in = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic wait_drain(input int exp_beats);
    int n;
    n = 0;
    while ((q.size() != 0 || m_valid) && n < 3000) begin
      @(negedge clk);
      #1 n++;
    end
    chk("drain", n < 3000, 1);
    chk("beat_count", beat_cnt, exp_beats);
  endtask

  task automatic send_row4(input logic [15:0] a, b, c, d, input int gap);
    send_px(a, gap); send_px(b, gap); send_px(c, gap); send_px(d, gap);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 valid_in = 1'($urandom_range(0, 1));
      data_in   = 16'($urandom);
      ready_out = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("reset_outs", {m_valid, m_ready_in, m_data, m_rl, m_fl}, {2'b01, 16'h0, 2'b00});
    end
    valid_in = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    // basic
    do_reset();
    send_row4(16'd1, 16'd2, 16'd3, 16'd4, 0);
    wait_drain(16);

    // backpressure
    do_reset();
    bp = 1'b1;
    send_row4(16'd1, 16'd2, 16'd3, 16'd4, 0);
    wait_drain(16);
    bp = 1'b0;

    // input gaps: idle in S_TAKE between pixels
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      send_px(16'(i), 4);
      if (i < 4) begin
        @(negedge clk);
        chk("gap_idle", {m_valid, m_ready_in}, 2'b01);
      end
    end
    wait_drain(16);

    // frame wrap on the two-row instance
    sel = 1'b1;
    do_reset();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 8; i++) send_px(16'(16 * (f + 1) + i), 0);
    wait_drain(64);
    sel = 1'b0;

    // reset during beat 11, asserted away from any clock edge
    do_reset();
    send_row4(16'd1, 16'd2, 16'd3, 16'd4, 0);
    begin
      int n;
      n = 0;
      while (beat_cnt < 11 && n < 500) begin
        @(negedge clk);
        #1 n++;
      end
      chk("reach_beat11", beat_cnt, 11);
    end
    rst_n = 1'b0;
    #1 chk("async_rst", {m_valid, m_ready_in, m_data, m_rl, m_fl}, {2'b01, 16'h0, 2'b00});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    beat_cnt = 0;
    send_row4(16'd9, 16'd8, 16'd7, 16'd6, 0);
    wait_drain(16);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
